// File: rtl/isa_dispatch_pkg.sv
// Shared definitions for the fetch/decode/dispatch controller: instruction
// field layout, reserved opcodes, FSM state encoding and the IP commit helper.
package isa_dispatch_pkg;

    // Instruction word field positions
    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_W   = 8;
    localparam int R0_LSB     = 8;
    localparam int R1_LSB     = 12;
    localparam int R2_LSB     = 16;
    localparam int REG_W      = 4;
    localparam int RSVD_LSB   = 20;

    // Opcodes with a fixed meaning; opcode N below NUM_UNITS selects unit N
    localparam logic [7:0] OP_BRC_EQ = 8'h00;
    localparam logic [7:0] OP_ALU    = 8'h01;
    localparam logic [7:0] OP_LDST   = 8'h02;
    localparam logic [7:0] OP_HALT   = 8'hFF;

    // Controller states
    typedef enum logic [2:0] {
        ST_FETCH    = 3'd0,
        ST_WAIT_MEM = 3'd1,
        ST_DECODE   = 3'd2,
        ST_EXEC     = 3'd3,
        ST_RELEASE  = 3'd4,
        ST_HALT     = 3'd5
    } state_t;

    // Next instruction pointer: branch target if taken, else fall through
    // (plain 64-bit addition, so the top of the address space wraps to 0)
    function automatic logic [63:0] next_ip(
        input logic [63:0] cur_ip,
        input logic        taken,
        input logic [63:0] target,
        input logic [63:0] step
    );
        logic [63:0] result;
        if (taken) begin
            result = target;
        end else begin
            result = cur_ip + step;
        end
        return result;
    endfunction

endpackage

// File: rtl/isa_dispatch_decode.sv
// Purely combinational instruction decoder: splits the fetched word into
// opcode and register fields and classifies the opcode.
module isa_decode
    import isa_dispatch_pkg::*;
#(
    parameter int NUM_UNITS = 8
) (
    input  logic [31:0]      instr,
    output logic [7:0]       opcode,
    output logic [REG_W-1:0] r0,
    output logic [REG_W-1:0] r1,
    output logic [REG_W-1:0] r2,
    output logic             is_halt,
    output logic             is_valid
);

    // Upper bits are reserved and deliberately ignored
    logic reserved_unused_s;

    assign reserved_unused_s = ^instr[31:RSVD_LSB];

    assign opcode   = instr[OPCODE_LSB +: OPCODE_W];
    assign r0       = instr[R0_LSB +: REG_W];
    assign r1       = instr[R1_LSB +: REG_W];
    assign r2       = instr[R2_LSB +: REG_W];
    assign is_halt  = (opcode == OP_HALT);
    assign is_valid = ({24'd0, opcode} < 32'(NUM_UNITS));

endmodule

// File: rtl/isa_dispatch.sv
// Fetch/decode/dispatch controller. Owns the instruction pointer, fetches one
// 32-bit word per instruction, enables exactly one executor unit and commits
// either the branch target or the fall-through address once the unit is done.
module isa_dispatch
    import isa_dispatch_pkg::*;
#(
    parameter int          NUM_UNITS    = 8,
    parameter logic [63:0] RESET_IP     = 64'h0,
    parameter int          INSTR_BYTES  = 4,
    parameter int          EXEC_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [63:0]          mem_addr,
    output logic                 mem_re,
    input  logic [31:0]          mem_data,
    input  logic                 mem_valid,
    output logic [NUM_UNITS-1:0] exec_en,
    output logic [3:0]           r0,
    output logic [3:0]           r1,
    output logic [3:0]           r2,
    input  logic [NUM_UNITS-1:0] exec_finished,
    input  logic                 ip_set,
    input  logic [63:0]          ip_val,
    output logic [63:0]          ip,
    output logic                 halted,
    output logic                 illegal
);

    localparam int               CNT_W      = (EXEC_TIMEOUT > 1) ? $clog2(EXEC_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = (EXEC_TIMEOUT > 0) ? CNT_W'(EXEC_TIMEOUT - 1) : {CNT_W{1'b0}};
    localparam logic             TIMEOUT_EN = (EXEC_TIMEOUT > 0) ? 1'b1 : 1'b0;
    localparam logic [63:0]      IP_STEP    = 64'(INSTR_BYTES);

    // State and datapath registers
    state_t               state_r;
    state_t               state_nxt_s;
    logic [63:0]          ip_r;
    logic [31:0]          instr_r;
    logic [3:0]           r0_r;
    logic [3:0]           r1_r;
    logic [3:0]           r2_r;
    logic                 branch_pending_r;
    logic [63:0]          branch_target_r;
    logic [CNT_W-1:0]     cnt_r;

    // Registered outputs and their next values
    logic [NUM_UNITS-1:0] exec_en_r;
    logic [NUM_UNITS-1:0] exec_en_nxt_s;
    logic                 mem_re_r;
    logic                 mem_re_nxt_s;
    logic                 halted_r;
    logic                 halted_nxt_s;
    logic                 illegal_r;
    logic                 illegal_nxt_s;

    // Decoder results for the latched instruction
    logic [7:0]           dec_opcode_s;
    logic [3:0]           dec_r0_s;
    logic [3:0]           dec_r1_s;
    logic [3:0]           dec_r2_s;
    logic                 dec_is_halt_s;
    logic                 dec_is_valid_s;

    // Status of the active executor
    logic                 finished_sel_s;
    logic                 timeout_hit_s;

    isa_decode #(
        .NUM_UNITS (NUM_UNITS)
    ) u_decode (
        .instr    (instr_r),
        .opcode   (dec_opcode_s),
        .r0       (dec_r0_s),
        .r1       (dec_r1_s),
        .r2       (dec_r2_s),
        .is_halt  (dec_is_halt_s),
        .is_valid (dec_is_valid_s)
    );

    // exec_en_r is one-hot on the selected unit during EXEC, so masking the
    // finished vector with it ignores every other unit
    assign finished_sel_s = |(exec_finished & exec_en_r);
    assign timeout_hit_s  = TIMEOUT_EN && (cnt_r == CNT_LAST);

    assign mem_addr = ip_r;
    assign ip       = ip_r;
    assign mem_re   = mem_re_r;
    assign exec_en  = exec_en_r;
    assign r0       = r0_r;
    assign r1       = r1_r;
    assign r2       = r2_r;
    assign halted   = halted_r;
    assign illegal  = illegal_r;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_FETCH: begin
                state_nxt_s = ST_WAIT_MEM;
            end
            ST_WAIT_MEM: begin
                if (mem_valid && mem_re_r) begin
                    state_nxt_s = ST_DECODE;
                end else begin
                    state_nxt_s = ST_WAIT_MEM;
                end
            end
            ST_DECODE: begin
                if (dec_is_valid_s) begin
                    state_nxt_s = ST_EXEC;
                end else begin
                    state_nxt_s = ST_HALT;
                end
            end
            ST_EXEC: begin
                if (finished_sel_s) begin
                    state_nxt_s = ST_RELEASE;
                end else if (timeout_hit_s) begin
                    state_nxt_s = ST_HALT;
                end else begin
                    state_nxt_s = ST_EXEC;
                end
            end
            ST_RELEASE: begin
                state_nxt_s = ST_FETCH;
            end
            ST_HALT: begin
                state_nxt_s = ST_HALT;
            end
            default: begin
                state_nxt_s = ST_HALT;
            end
        endcase
    end

    // Output logic: values the outputs take in the state being entered
    always_comb begin
        mem_re_nxt_s  = 1'b0;
        exec_en_nxt_s = {NUM_UNITS{1'b0}};
        halted_nxt_s  = 1'b0;
        illegal_nxt_s = 1'b0;
        case (state_nxt_s)
            ST_FETCH, ST_WAIT_MEM: begin
                mem_re_nxt_s = 1'b1;
            end
            ST_EXEC: begin
                if (state_r == ST_DECODE) begin
                    exec_en_nxt_s = NUM_UNITS'(1'b1) << dec_opcode_s;
                end else begin
                    exec_en_nxt_s = exec_en_r;
                end
            end
            ST_HALT: begin
                halted_nxt_s = 1'b1;
                if (state_r == ST_HALT) begin
                    illegal_nxt_s = illegal_r;
                end else if (state_r == ST_DECODE) begin
                    illegal_nxt_s = ~dec_is_halt_s;
                end else begin
                    illegal_nxt_s = 1'b1;
                end
            end
            default: begin
                mem_re_nxt_s = 1'b0;
            end
        endcase
    end

    // Output registers; reset drops exec_en without waiting for a clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_re_r  <= 1'b0;
            exec_en_r <= {NUM_UNITS{1'b0}};
            halted_r  <= 1'b0;
            illegal_r <= 1'b0;
        end else begin
            mem_re_r  <= mem_re_nxt_s;
            exec_en_r <= exec_en_nxt_s;
            halted_r  <= halted_nxt_s;
            illegal_r <= illegal_nxt_s;
        end
    end

    // Datapath: instruction latch, register fields, branch capture, timeout
    // counter and IP commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ip_r             <= RESET_IP;
            instr_r          <= 32'd0;
            r0_r             <= 4'd0;
            r1_r             <= 4'd0;
            r2_r             <= 4'd0;
            branch_pending_r <= 1'b0;
            branch_target_r  <= 64'd0;
            cnt_r            <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_WAIT_MEM: begin
                    if (mem_valid) begin
                        instr_r <= mem_data;
                    end
                end
                ST_DECODE: begin
                    r0_r             <= dec_r0_s;
                    r1_r             <= dec_r1_s;
                    r2_r             <= dec_r2_s;
                    branch_pending_r <= 1'b0;
                    cnt_r            <= {CNT_W{1'b0}};
                end
                ST_EXEC: begin
                    cnt_r <= cnt_r + CNT_W'(1'b1);
                    // A later pulse overwrites an earlier target
                    if (ip_set) begin
                        branch_target_r  <= ip_val;
                        branch_pending_r <= 1'b1;
                    end
                end
                ST_RELEASE: begin
                    ip_r <= next_ip(ip_r, branch_pending_r, branch_target_r, IP_STEP);
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

endmodule

// File: doc/isa_dispatch.md
Name: isa_dispatch

Overview:
- Fetch/decode/dispatch controller sitting directly upstream of the isa_* executor units (branch, ALU, load/store).
- Owns the instruction pointer and fetches a 32-bit instruction word at the current IP.
- Decodes the opcode and register fields, enables exactly one executor, then waits for its finished.
- Commits the next IP: the branch target if the executor pulsed ip_set, otherwise IP + INSTR_BYTES.

Parameters:
- NUM_UNITS, 8: number of executor units; opcode N (N < NUM_UNITS) enables unit N.
- RESET_IP, 64'h0: IP value loaded on reset.
- INSTR_BYTES, 4: IP increment for fall-through.
- EXEC_TIMEOUT, 255: maximum EXEC cycles before a forced halt; 0 disables the timeout.

Ports:
- clk  in  1  system clock; all state changes on its posedge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_addr  out  64  fetch address; equals ip while mem_re=1.
- mem_re  out  1  fetch request; held until mem_valid.
- mem_data  in  32  instruction word; valid when mem_valid=1.
- mem_valid  in  1  fetch response strobe; ignored unless mem_re=1.
- exec_en  out  NUM_UNITS  one-hot executor enable; all zero outside EXEC.
- r0, r1, r2  out  4 each  register fields; stable for the whole of EXEC.
- exec_finished  in  NUM_UNITS  per-unit finished (level).
- ip_set  in  1  branch-taken pulse from the active executor (OR of unit outputs).
- ip_val  in  64  branch target; valid with ip_set.
- ip  out  64  current instruction pointer.
- halted  out  1  high in HALT.
- illegal  out  1  high in HALT if the cause was a bad opcode or a timeout.

Behaviour:
- Reset (async, rst_n=0):
  - ip=RESET_IP, exec_en=0, mem_re=0, r0=r1=r2=0, halted=0, illegal=0.
  - branch_pending=0, state=FETCH.
  - Mid-EXEC reset drops exec_en immediately; the executor self-clears on its enable falling edge.
- Instruction format: [7:0] opcode, [11:8] r0, [15:12] r1, [19:16] r2, [31:20] reserved and ignored.
- FETCH: mem_re=1, mem_addr=ip -> WAIT_MEM.
- WAIT_MEM:
  - Hold mem_re=1.
  - On mem_valid: latch mem_data into instr, mem_re=0 -> DECODE.
  - No timeout here; the memory is trusted.
- DECODE: latch r0/r1/r2 and clear branch_pending, then:
  - opcode < NUM_UNITS -> EXEC.
  - opcode 8'hFF -> HALT with illegal=0.
  - any other opcode -> HALT with illegal=1.
- EXEC:
  - exec_en = 1<<opcode; cycle counter counts up.
  - ip_set=1 in any cycle: branch_target<=ip_val, branch_pending<=1; a later ip_set overwrites.
  - On exec_finished[opcode]=1 -> RELEASE; ip_set in that same cycle still counts (target taken).
  - finished from a non-selected unit is ignored.
  - Counter reaching EXEC_TIMEOUT (nonzero) -> HALT with illegal=1, exec_en=0.
- RELEASE (exactly 1 cycle):
  - exec_en=0, so the executor sees its enable fall and clears finished.
  - ip <= branch_pending ? branch_target : ip+INSTR_BYTES, arithmetic modulo 2^64 (FFFF_FFFF_FFFF_FFFC+4 -> 0).
  - -> FETCH.
- HALT: absorbing; exec_en=0, mem_re=0, halted=1; only reset exits.
- Latency without a branch: FETCH 1 + WAIT_MEM >=1 + DECODE 1 + EXEC (unit latency) + RELEASE 1.
  - With single-cycle memory, exec_en rises 3 cycles after FETCH entry.
- Invariants:
  - exec_en is one-hot or zero, never multi-hot.
  - r0/r1/r2 never change while exec_en != 0.
  - ip changes only in RELEASE or on reset.

Decomposition:
- Shared include isa_defs.vh holds:
  - opcode constants (OP_HALT=8'hFF, per-unit opcodes such as OP_BRC_EQ);
  - field bit positions;
  - state encodings (FETCH, WAIT_MEM, DECODE, EXEC, RELEASE, HALT).
- One combinational sub-module, isa_decode: instr[31:0] -> opcode, r0, r1, r2, is_halt, is_valid(NUM_UNITS).
- The FSM, IP register and timeout counter stay in isa_dispatch.

Test Plan:
- Reset then mem_data=32'h0003_2101 on the first fetch (opcode 1) with 1-cycle mem_valid -> mem_addr=0; exec_en=8'b0000_0010 and r0=1, r1=2, r2=3 on the 3rd cycle; unit finishes after 4 cycles -> exec_en=0 for one cycle, ip=4, next fetch at addr 4.
- Branch: opcode 0; the unit pulses ip_set with ip_val=64'h100 two cycles before finished -> ip=64'h100 after RELEASE; also check ip_set and finished in the same cycle -> ip=64'h100.
- Opcode 8'hFF -> halted=1, illegal=0, exec_en=0, mem_re=0 held for 20 cycles. Opcode 8'h20 with NUM_UNITS=8 -> halted=1, illegal=1.
- EXEC_TIMEOUT=10, unit never finishes -> exactly 10 EXEC cycles, then halted=1, illegal=1, exec_en=0. finished from a non-selected unit during EXEC has no effect.
- rst_n=0 pulsed asynchronously mid-EXEC (not on a clock edge) -> exec_en drops immediately, ip=RESET_IP, fetch restarts at RESET_IP after rst_n=1.
- ip=64'hFFFF_FFFF_FFFF_FFFC, non-branch instruction -> ip wraps to 0; mem_valid delayed 5 cycles -> mem_re held high and mem_addr stable throughout.
